// File: rtl/generator_sygnalow_rozrzadu.sv
// generator_sygnalow_rozrzadu
//
// Crank-angle timing generator for a four-stroke engine. An external
// one-degree tick advances the crank angle over a KAT_MAX-degree cycle.
// Each of four channels (intake valve, exhaust valve, injector, spark) is
// driven high while the angle lies inside its on/off degree window. The
// window thresholds are shadow-latched only at cycle boundaries, so a change
// in the incoming angle table never glitches an output mid-cycle.
//
// Optional build macro: ZNACZNIK_GMP_EN adds a TDC marker input that forces
// the angle to 0 and a sticky synchronisation-error flag.
//
// Ports:
//   clk                            system clock, rising edge
//   rst_n                          asynchronous active-low reset
//   praca                          run request (1 = engine running)
//   impuls_stopnia                 one-degree advance tick
//   stopnie_zaswiecenie_* / stopnie_zgaszenie_*
//                                  on/off angles for ssacy, wydechowy, wtrysk, iskra
//   znacznik_gmp                   (ZNACZNIK_GMP_EN only) TDC marker pulse
//   kat                            current crank angle
//   zawor_ssacy, zawor_wydechowy,
//   wtrysk, iskra                  registered channel outputs
//   znacznik_cyklu                 one-clk pulse when the angle wraps to 0
//   licznik_cykli                  completed cycles, wraps modulo 2^CYKL_W
//   aktywny                        1 while running or running out
//   blad_synchronizacji            (ZNACZNIK_GMP_EN only) sticky marker error

module generator_sygnalow_rozrzadu #(
  parameter int KAT_MAX = 720,
  parameter int KAT_W   = 10,
  parameter int CYKL_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              praca,
  input  logic              impuls_stopnia,
`ifdef ZNACZNIK_GMP_EN
  input  logic              znacznik_gmp,
`endif
  input  logic [KAT_W-1:0]  stopnie_zaswiecenie_ssacy,
  input  logic [KAT_W-1:0]  stopnie_zgaszenie_ssacy,
  input  logic [KAT_W-1:0]  stopnie_zaswiecenie_wydechowy,
  input  logic [KAT_W-1:0]  stopnie_zgaszenie_wydechowy,
  input  logic [KAT_W-1:0]  stopnie_zaswiecenie_wtrysk,
  input  logic [KAT_W-1:0]  stopnie_zgaszenie_wtrysk,
  input  logic [KAT_W-1:0]  stopnie_zaswiecenie_iskra,
  input  logic [KAT_W-1:0]  stopnie_zgaszenie_iskra,
  output logic [KAT_W-1:0]  kat,
  output logic              zawor_ssacy,
  output logic              zawor_wydechowy,
  output logic              wtrysk,
  output logic              iskra,
  output logic              znacznik_cyklu,
  output logic [CYKL_W-1:0] licznik_cykli,
  output logic              aktywny
`ifdef ZNACZNIK_GMP_EN
  ,
  output logic              blad_synchronizacji
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DOBIEG = 2'd2
  } stan_t;

  localparam int                 KANALY  = 4;
  localparam logic [KAT_W-1:0]   KAT_OST = KAT_W'(KAT_MAX - 1);

  stan_t             stan, stan_nast;
  logic [KAT_W-1:0]  kat_nast;
  logic              przeladuj;
  logic              ostatni;
  logic              zawiniecie;
  logic              gmp;

  // Channel order everywhere: 0 intake, 1 exhaust, 2 injector, 3 spark.
  logic [KAT_W-1:0]  wej_zal  [KANALY];
  logic [KAT_W-1:0]  wej_zgas [KANALY];
  logic [KAT_W-1:0]  cien_zal [KANALY];
  logic [KAT_W-1:0]  cien_zgas[KANALY];
  logic [KANALY-1:0] kanaly, kanaly_nast;

  assign wej_zal[0]  = stopnie_zaswiecenie_ssacy;
  assign wej_zgas[0] = stopnie_zgaszenie_ssacy;
  assign wej_zal[1]  = stopnie_zaswiecenie_wydechowy;
  assign wej_zgas[1] = stopnie_zgaszenie_wydechowy;
  assign wej_zal[2]  = stopnie_zaswiecenie_wtrysk;
  assign wej_zgas[2] = stopnie_zgaszenie_wtrysk;
  assign wej_zal[3]  = stopnie_zaswiecenie_iskra;
  assign wej_zgas[3] = stopnie_zgaszenie_iskra;

`ifdef ZNACZNIK_GMP_EN
  assign gmp = znacznik_gmp;
`else
  assign gmp = 1'b0;
`endif

  // A wrap happens either on the tick leaving the last degree or on a TDC
  // marker; the marker takes priority over a simultaneous tick. Both are
  // ignored while idle.
  assign ostatni    = (kat == KAT_OST);
  assign zawiniecie = (stan != IDLE) && (gmp || (impuls_stopnia && ostatni));

  // Window test on one channel. Thresholds beyond the cycle disable the
  // channel; on > off means the window straddles the wrap; equal means empty.
  function automatic logic w_oknie(input logic [KAT_W-1:0] k,
                                   input logic [KAT_W-1:0] a,
                                   input logic [KAT_W-1:0] b);
    logic wynik;
    if (a > KAT_OST || b > KAT_OST) wynik = 1'b0;
    else if (a < b)                 wynik = (k >= a) && (k < b);
    else if (a > b)                 wynik = (k >= a) || (k < b);
    else                            wynik = 1'b0;
    return wynik;
  endfunction

  // Next-state and next-angle logic.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves
    // it unassigned and no latch is inferred.
    stan_nast = stan;
    kat_nast  = kat;
    przeladuj = 1'b0;
    case (stan)
      IDLE: begin
        kat_nast = '0;
        if (praca) begin
          stan_nast = RUN;
          przeladuj = 1'b1;
        end
      end
      RUN: begin
        if (zawiniecie) begin
          kat_nast  = '0;
          przeladuj = 1'b1;
        end else if (impuls_stopnia) begin
          kat_nast = kat + 1'b1;
        end
        stan_nast = praca ? RUN : DOBIEG;
      end
      DOBIEG: begin
        // The wrap ends the run-out even if praca has just come back.
        if (zawiniecie) begin
          kat_nast  = '0;
          stan_nast = IDLE;
        end else begin
          if (impuls_stopnia) kat_nast = kat + 1'b1;
          stan_nast = praca ? RUN : DOBIEG;
        end
      end
      default: begin
        kat_nast  = '0;
        stan_nast = IDLE;
      end
    endcase
  end

  // Channels follow the registered angle one clk later. They are held low
  // while idle and drop together with the angle when the run-out ends.
  always_comb begin
    kanaly_nast = '0;
    for (int c = 0; c < KANALY; c++) begin
      kanaly_nast[c] = (stan != IDLE) && (stan_nast != IDLE) &&
                       w_oknie(kat, cien_zal[c], cien_zgas[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stan           <= IDLE;
      kat            <= '0;
      kanaly         <= '0;
      znacznik_cyklu <= 1'b0;
      licznik_cykli  <= '0;
      aktywny        <= 1'b0;
      // NOTE: the shadow thresholds are a handful of flops, not a RAM, so
      // they are reset like any other state.
      for (int c = 0; c < KANALY; c++) begin
        cien_zal[c]  <= '0;
        cien_zgas[c] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      stan           <= stan_nast;
      kat            <= kat_nast;
      kanaly         <= kanaly_nast;
      znacznik_cyklu <= zawiniecie;
      aktywny        <= (stan_nast != IDLE);
      if (zawiniecie) licznik_cykli <= licznik_cykli + 1'b1;
      if (przeladuj) begin
        for (int c = 0; c < KANALY; c++) begin
          cien_zal[c]  <= wej_zal[c];
          cien_zgas[c] <= wej_zgas[c];
        end
      end
    end
  end

`ifdef ZNACZNIK_GMP_EN
  // A marker anywhere but the last degree means ticks were lost or gained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blad_synchronizacji <= 1'b0;
    end else if (stan == IDLE && praca) begin
      blad_synchronizacji <= 1'b0;
    end else if (stan != IDLE && gmp && !ostatni) begin
      blad_synchronizacji <= 1'b1;
    end
  end
`endif

  assign zawor_ssacy     = kanaly[0];
  assign zawor_wydechowy = kanaly[1];
  assign wtrysk          = kanaly[2];
  assign iskra           = kanaly[3];

endmodule

// File: tb/tb_generator_sygnalow_rozrzadu.sv
// Self-checking bench for generator_sygnalow_rozrzadu: reset checks, a table
// of single-channel window vectors, hand-written multi-cycle sequences and a
// randomized run compared against an angle/window reference model.

module tb_generator_sygnalow_rozrzadu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       praca;
  logic       tick;
  logic       gmp;
  logic [9:0] zal [4];
  logic [9:0] zgas[4];

  logic [9:0]  kat;
  logic        zs, zw, wt, isk;
  logic        znak;
  logic [15:0] licz;
  logic        akt;
  logic        blad;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  generator_sygnalow_rozrzadu dut (
    .clk                           (clk),
    .rst_n                         (rst_n),
    .praca                         (praca),
    .impuls_stopnia                (tick),
`ifdef ZNACZNIK_GMP_EN
    .znacznik_gmp                  (gmp),
    .blad_synchronizacji           (blad),
`endif
    .stopnie_zaswiecenie_ssacy     (zal[0]),
    .stopnie_zgaszenie_ssacy       (zgas[0]),
    .stopnie_zaswiecenie_wydechowy (zal[1]),
    .stopnie_zgaszenie_wydechowy   (zgas[1]),
    .stopnie_zaswiecenie_wtrysk    (zal[2]),
    .stopnie_zgaszenie_wtrysk      (zgas[2]),
    .stopnie_zaswiecenie_iskra     (zal[3]),
    .stopnie_zgaszenie_iskra       (zgas[3]),
    .kat                           (kat),
    .zawor_ssacy                   (zs),
    .zawor_wydechowy               (zw),
    .wtrysk                        (wt),
    .iskra                         (isk),
    .znacznik_cyklu                (znak),
    .licznik_cykli                 (licz),
    .aktywny                       (akt)
  );

`ifndef ZNACZNIK_GMP_EN
  assign blad = 1'b0;
`endif

  task automatic check(input string nazwa, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", nazwa, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Mode: 0 stopped, 1 running, 2 running out. The model tracks the angle
  // as an integer and decides window membership by modular distance.
  int         m_tryb;
  int         m_kat;
  int         m_zal[4], m_zgas[4];
  logic [3:0] m_kan;
  logic       m_znak;
  int         m_licz;
  logic       m_akt;
  logic       m_blad;

  function automatic logic w_oknie(int k, int a, int b);
    if (a >= 720 || b >= 720) return 1'b0;
    // Degrees travelled since switch-on must be less than the window length.
    return ((k - a + 720) % 720) < ((b - a + 720) % 720);
  endfunction

  task automatic model_reset();
    m_tryb = 0; m_kat = 0; m_kan = '0; m_znak = 1'b0;
    m_licz = 0; m_akt = 1'b0; m_blad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      m_zal[c] = 0; m_zgas[c] = 0;
    end
  endtask

  task automatic model_krok();
    int         nt;
    logic       wrap;
    logic [3:0] kan;
    wrap = (m_tryb != 0) && (gmp || (tick && m_kat == 719));
    if (m_tryb == 0)      nt = praca ? 1 : 0;
    else if (wrap)        nt = (m_tryb == 1) ? (praca ? 1 : 2) : 0;
    else                  nt = praca ? 1 : 2;
    // Outputs describe the previous angle, and are low if either this or
    // the previous period was spent stopped.
    for (int c = 0; c < 4; c++)
      kan[c] = (m_tryb != 0) && (nt != 0) && w_oknie(m_kat, m_zal[c], m_zgas[c]);
    if (m_tryb == 0 && praca)                 m_blad = 1'b0;
    else if (m_tryb != 0 && gmp && m_kat != 719) m_blad = 1'b1;
    if ((m_tryb == 0 && praca) || (wrap && m_tryb == 1)) begin
      for (int c = 0; c < 4; c++) begin
        m_zal[c] = int'(zal[c]); m_zgas[c] = int'(zgas[c]);
      end
    end
    if (m_tryb == 0 || wrap) m_kat = 0;
    else if (tick)           m_kat = m_kat + 1;
    m_znak = wrap;
    if (wrap) m_licz = (m_licz + 1) % 65536;
    m_akt  = (nt != 0);
    m_kan  = kan;
    m_tryb = nt;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    model_krok();
    #1;
  endtask

  task automatic tick_n(input int n);
    tick = 1'b1;
    repeat (n) cyc();
    tick = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; praca = 1'b0; tick = 1'b0; gmp = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic clear_thr();
    for (int c = 0; c < 4; c++) begin
      zal[c] = '0; zgas[c] = '0;
    end
  endtask

  typedef struct {
    int   on;
    int   off;
    int   ticks;
    logic exp_ssacy;
  } vec_t;

  vec_t tab[15];

  initial begin
    tab[0]  = '{140, 426, 139, 1'b0};
    tab[1]  = '{140, 426, 140, 1'b1};
    tab[2]  = '{140, 426, 425, 1'b1};
    tab[3]  = '{140, 426, 426, 1'b0};
    tab[4]  = '{674, 190, 673, 1'b0};
    tab[5]  = '{674, 190, 674, 1'b1};
    tab[6]  = '{674, 190, 719, 1'b1};
    tab[7]  = '{674, 190, 720, 1'b1};
    tab[8]  = '{674, 190, 909, 1'b1};
    tab[9]  = '{674, 190, 910, 1'b0};
    tab[10] = '{250, 250, 250, 1'b0};
    tab[11] = '{800, 100, 50,  1'b0};
    tab[12] = '{100, 800, 500, 1'b0};
    tab[13] = '{0,   720, 10,  1'b0};
    tab[14] = '{0,   719, 0,   1'b1};

    clear_thr();
    do_reset();

    // Reset state.
    check("reset_kat", kat, 0);
    check("reset_kanaly", {zs, zw, wt, isk}, 0);
    check("reset_znacznik", znak, 0);
    check("reset_licznik", licz, 0);
    check("reset_aktywny", akt, 0);
    check("reset_blad", blad, 0);

    // Ticks while idle are ignored.
    tick_n(5);
    check("idle_kat", kat, 0);

    // Table of intake windows.
    foreach (tab[i]) begin
      clear_thr();
      do_reset();
      zal[0]  = 10'(tab[i].on);
      zgas[0] = 10'(tab[i].off);
      praca = 1'b1;
      tick  = 1'b1;  // ignored on the idle-to-run clk
      cyc();
      tick  = 1'b0;
      tick_n(tab[i].ticks);
      cyc();
      check($sformatf("tab%0d_kat", i), kat, tab[i].ticks % 720);
      check($sformatf("tab%0d_ssacy", i), zs, tab[i].exp_ssacy);
      check($sformatf("tab%0d_inne", i), {zw, wt, isk}, 0);
    end

    // Spark thresholds changed mid-cycle take effect after the wrap.
    clear_thr();
    do_reset();
    zal[3] = 10'd525; zgas[3] = 10'd545;
    praca = 1'b1;
    cyc();
    tick_n(300);
    zal[3] = 10'd515; zgas[3] = 10'd555;
    tick_n(215); cyc(); check("iskra_old_515", isk, 0);
    tick_n(10);  cyc(); check("iskra_old_525", isk, 1);
    tick_n(19);  cyc(); check("iskra_old_544", isk, 1);
    tick_n(1);   cyc(); check("iskra_old_545", isk, 0);
    tick_n(174);
    tick_n(1);
    check("wrap_kat", kat, 0);
    check("wrap_znacznik", znak, 1);
    check("wrap_licznik", licz, 1);
    cyc();
    check("wrap_znacznik_konczy", znak, 0);
    tick_n(515); cyc(); check("iskra_new_515", isk, 1);
    tick_n(39);  cyc(); check("iskra_new_554", isk, 1);
    tick_n(1);   cyc(); check("iskra_new_555", isk, 0);

    // Run-out: praca drops at 400, counting continues until the wrap.
    clear_thr();
    do_reset();
    zal[0] = 10'd140; zgas[0] = 10'd426;
    zal[1] = 10'd674; zgas[1] = 10'd190;
    praca = 1'b1;
    cyc();
    tick_n(400);
    praca = 1'b0;
    cyc();
    check("dobieg_aktywny", akt, 1);
    check("dobieg_ssacy_400", zs, 1);
    tick_n(26);  cyc(); check("dobieg_ssacy_426", zs, 0);
    tick_n(248); cyc(); check("dobieg_wydech_674", zw, 1);
    tick_n(45);
    tick_n(1);
    check("dobieg_koniec_kat", kat, 0);
    check("dobieg_koniec_aktywny", akt, 0);
    check("dobieg_koniec_kanaly", {zs, zw, wt, isk}, 0);
    check("dobieg_koniec_znacznik", znak, 1);
    check("dobieg_koniec_licznik", licz, 1);
    tick_n(5);
    check("idle_po_dobiegu_kat", kat, 0);

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    clear_thr();
    do_reset();
    zal[0] = 10'd140; zgas[0] = 10'd426;
    praca = 1'b1;
    cyc();
    tick_n(200);
    cyc();
    check("przed_resetem_ssacy", zs, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_ssacy", zs, 0);
    check("async_reset_kat", kat, 0);
    check("async_reset_aktywny", akt, 0);
    model_reset();
    #1 rst_n = 1'b1;

`ifdef ZNACZNIK_GMP_EN
    // TDC marker: on the last degree it is a clean wrap; elsewhere it is an
    // error that stays set until the next start.
    clear_thr();
    do_reset();
    praca = 1'b1;
    cyc();
    tick_n(719);
    gmp = 1'b1;
    cyc();
    gmp = 1'b0;
    check("gmp719_kat", kat, 0);
    check("gmp719_blad", blad, 0);
    check("gmp719_znacznik", znak, 1);
    tick_n(300);
    gmp = 1'b1; tick = 1'b1;
    cyc();
    gmp = 1'b0; tick = 1'b0;
    check("gmp300_kat", kat, 0);
    check("gmp300_blad", blad, 1);
    check("gmp300_licznik", licz, 2);
    tick_n(50);
    praca = 1'b0;
    tick_n(670);
    check("gmp_idle_aktywny", akt, 0);
    check("gmp_idle_blad", blad, 1);
    gmp = 1'b1;
    cyc();
    gmp = 1'b0;
    check("gmp_idle_ignorowany", licz, 3);
    praca = 1'b1;
    cyc();
    check("gmp_start_blad", blad, 0);
`endif

    // Randomized run against the reference model.
    clear_thr();
    do_reset();
    praca = 1'b1;
    for (int c = 0; c < 4; c++) begin
      zal[c]  = 10'($urandom_range(0, 799));
      zgas[c] = 10'($urandom_range(0, 799));
    end
    for (int n = 0; n < 8000; n++) begin
      tick = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 399) == 0) praca = ~praca;
      if ($urandom_range(0, 499) == 0) begin
        for (int c = 0; c < 4; c++) begin
          zal[c]  = 10'($urandom_range(0, 799));
          zgas[c] = 10'($urandom_range(0, 799));
        end
      end
`ifdef ZNACZNIK_GMP_EN
      gmp = ($urandom_range(0, 1499) == 0);
`endif
      cyc();
      check($sformatf("losowy_%0d", n),
            {kat, zs, zw, wt, isk, znak, licz, akt, blad},
            {10'(m_kat), m_kan[0], m_kan[1], m_kan[2], m_kan[3], m_znak,
             16'(m_licz), m_akt,
`ifdef ZNACZNIK_GMP_EN
             m_blad
`else
             1'b0
`endif
            });
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/generator_sygnalow_rozrzadu.md
Name: generator_sygnalow_rozrzadu

Overview:
Downstream consumer of the variable valve-timing angle table. Tracks crank angle over a 720-degree four-stroke cycle from an external one-degree tick. Compares the angle against the eight on/off degree thresholds and drives four registered control outputs: intake valve, exhaust valve, injector, spark. Thresholds are shadow-latched only at cycle boundaries, so a mid-cycle rpm change never glitches an output.

Parameters:
KAT_MAX, 720, degrees per engine cycle; the angle counts 0..KAT_MAX-1.
KAT_W, 10, width of the angle and threshold buses.
CYKL_W, 16, width of the completed-cycle counter.

Ports:
clk  in  1  system clock, all logic on its rising edge
rst_n  in  1  asynchronous, active-low reset
praca  in  1  run request; 1 = engine running
impuls_stopnia  in  1  one-clk pulse, advance angle by one degree
stopnie_zaswiecenie_ssacy / stopnie_zgaszenie_ssacy  in  KAT_W  intake on/off angle
stopnie_zaswiecenie_wydechowy / stopnie_zgaszenie_wydechowy  in  KAT_W  exhaust on/off angle
stopnie_zaswiecenie_wtrysk / stopnie_zgaszenie_wtrysk  in  KAT_W  injector on/off angle
stopnie_zaswiecenie_iskra / stopnie_zgaszenie_iskra  in  KAT_W  spark on/off angle
kat  out  KAT_W  current crank angle
zawor_ssacy, zawor_wydechowy, wtrysk, iskra  out  1  channel outputs
znacznik_cyklu  out  1  one-clk pulse on every angle wrap to 0
licznik_cykli  out  CYKL_W  completed cycles, wraps modulo 2^CYKL_W
aktywny  out  1  1 in RUN or DOBIEG

Behaviour:
- Reset (async, rst_n=0): state IDLE. kat, all channel outputs, znacznik_cyklu, licznik_cykli, aktywny and all shadow thresholds = 0.
- States:
  - IDLE: kat held at 0, all outputs 0, ticks ignored. praca=1 -> RUN; the same clk loads all eight shadow thresholds. Any tick in that clk is ignored.
  - RUN: each tick increments kat. At kat=KAT_MAX-1 a tick wraps kat to 0. On wrap: pulse znacznik_cyklu, increment licznik_cykli, reload shadows from the inputs. praca=0 -> DOBIEG.
  - DOBIEG (run-out): ticks continue counting. praca=1 -> RUN; no reload, no kat change beyond the tick. The wrap tick -> IDLE: znacznik_cyklu and licznik_cykli still update, no shadow reload.
- Channel window, per channel, on=A, off=B (shadow values), evaluated on the registered kat:
  - A<B: active when A<=kat<B.
  - A>B (wrap, e.g. exhaust 674/190): active when kat>=A or kat<B.
  - A==B: never active.
  - A>=KAT_MAX or B>=KAT_MAX: channel forced 0 for the whole cycle.
- Latency: channel outputs are registered and change exactly 1 clk after kat changes. kat changes 1 clk after the tick.
- Channel outputs are forced 0 in IDLE. On entering IDLE they drop in the same clk that kat returns to 0.
- Input threshold changes mid-cycle have no effect until the next wrap or IDLE->RUN.
- A tick asserted for several consecutive clks advances kat once per clk; no edge detection.
- aktywny is registered and mirrors the state.

Optional Feature:
Macro ZNACZNIK_GMP_EN.
- With it:
  - Adds input znacznik_gmp (1-bit TDC marker pulse) and output blad_synchronizacji (1-bit).
  - In RUN or DOBIEG, a marker forces kat to 0 next clk with full wrap side effects (pulse, count, reload in RUN; -> IDLE in DOBIEG).
  - A marker and a tick in the same clk: marker wins.
  - A marker when kat != KAT_MAX-1 sets blad_synchronizacji (sticky). It clears only on reset or IDLE->RUN.
  - A marker in IDLE is ignored.
- Without it: neither port exists; the angle is driven purely by ticks.

Test Plan:
- Reset, then praca=1 with intake 140/426: after 140 ticks kat=140 and zawor_ssacy=1 one clk later; at kat=426 it returns to 0.
- Exhaust 674/190: zawor_wydechowy=1 for kat 674..719 and 0..189, 0 for 190..673. The wrap produces znacznik_cyklu for 1 clk and licznik_cykli=1.
- Change the spark inputs from 525/545 to 515/555 at kat=300: this cycle spark is high for 525..544. After the wrap, spark is high for 515..554.
- praca=0 at kat=400: counting continues and the outputs keep toggling. At the wrap, state is IDLE, kat=0, aktywny=0, all outputs 0. Further ticks leave kat=0.
- Thresholds 250/250 and 800/100 on two channels -> both stay 0 over a full cycle. rst_n pulsed low mid-cycle -> all outputs 0 immediately, state IDLE.
- With ZNACZNIK_GMP_EN: marker at kat=719 -> kat=0, no error. Marker at kat=300 together with a tick -> kat=0 and blad_synchronizacji=1, held until the next IDLE->RUN.
